pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk input 1, core clock; rst input 1, synchronous active-high reset.
REQ-002 SHALL have inputs stallreq_if, stallreq_id, stallreq_ex and stallreq_mem, each 1 bit: stage hold requests for fetch-bus wait, load-use, multi-cycle ALU and data-bus wait respectively.
REQ-003 SHALL have input excepttype_i, 32 bits: exception code from the MEM stage; 0 means none.
REQ-004 SHALL have input cp0_epc_i, 32 bits: current CP0 EPC value.
REQ-005 SHALL have input bus_busy_i, 1 bit: a bus transaction is in flight and must not be abandoned.
REQ-006 SHALL have output stall, 6 bits: bit0 = PC, bit1 = IF/ID, bit2 = ID/EX, bit3 = EX/MEM, bit4 = MEM/WB, bit5 = WB.
REQ-007 SHALL have outputs flush, 1 bit (pipeline-register clear pulse), and new_pc, 32 bits (redirect target, valid while flush = 1).
REQ-008 SHALL have output stall_cycles, 16 bits: saturating count of cycles in which stall != 0.
REQ-009 SHALL define these parameters: EXC_VECTOR, default 32'h00000020, general exception entry; EXC_ERET, default 32'h0000000e, ERET code.

Function
REQ-010 SHALL implement an FSM with states RUN, WAIT_BUS and FLUSH.
REQ-011 In RUN with excepttype_i == 0, stall SHALL be chosen combinationally by priority mem > ex > id > if.
REQ-012 The stall encodings SHALL be: mem 6'b011111; ex 6'b001111; id 6'b000111; if 6'b000011; no request 6'b000000.
REQ-013 In RUN with excepttype_i != 0, the block SHALL drive stall = 6'b111111 and latch the target: cp0_epc_i if excepttype_i == EXC_ERET, else EXC_VECTOR.
REQ-014 From that RUN cycle, the next state SHALL be FLUSH if bus_busy_i = 0, else WAIT_BUS.
REQ-015 In WAIT_BUS, stall SHALL be 6'b111111 and the latched target SHALL be held.
REQ-016 WAIT_BUS SHALL go to FLUSH in the cycle after bus_busy_i is sampled 0.
REQ-017 In WAIT_BUS, further excepttype_i values SHALL be ignored.
REQ-018 In FLUSH, flush SHALL be 1, new_pc SHALL equal the latched target, and stall SHALL be 6'b000000 regardless of stall requests.
REQ-019 FLUSH SHALL always last exactly one cycle and then return to RUN.
REQ-020 Exceptions SHALL be detected only in RUN; excepttype_i during FLUSH SHALL be ignored.
REQ-021 Exception-to-flush latency SHALL be 1 cycle when bus_busy_i = 0, and 1 + (number of busy cycles) otherwise.
REQ-022 Outside FLUSH, flush SHALL be 0 and new_pc SHALL be 32'h0.
REQ-023 flush and new_pc SHALL be registered outputs; stall SHALL be combinational from state and inputs.
REQ-024 stall_cycles SHALL increment in each cycle where stall != 0 and SHALL saturate at 16'hFFFF.
REQ-025 When an exception coincides with any stallreq, the exception SHALL take precedence (stall = 6'b111111).

Reset
REQ-026 On rst = 1 at a clk edge, the block SHALL set state to RUN, flush to 0, new_pc to 0, the latched target to 0 and stall_cycles to 0.
REQ-027 While rst = 1, stall SHALL be 6'b000000.
REQ-028 Reset asserted in WAIT_BUS or FLUSH SHALL abandon the pending redirect; no flush SHALL follow the reset.

Structure
REQ-029 The stall encodings, EXC_VECTOR, EXC_ERET and the Stop/NoStop constants SHALL live in the shared defines package.
REQ-030 The state encoding SHALL be local to the module.
REQ-031 The block SHALL be a single module with no sub-modules.
REQ-032 It SHALL drive the stall and flush inputs of every pipeline register (if_id, id_ex, ex_mem, mem_wb) and the pc_reg redirect.

Verification
REQ-033 Bench SHALL check: stallreq_ex = 1 and stallreq_if = 1 in the same cycle -> stall = 6'b001111; stall_cycles increments by 1.
REQ-034 Bench SHALL check: excepttype_i = 32'h8 with bus_busy_i = 0 -> stall = 6'b111111 that cycle; next cycle flush = 1, new_pc = 32'h20, stall = 0; the cycle after, flush = 0.
REQ-035 Bench SHALL check: excepttype_i = 32'he with cp0_epc_i = 32'h0000_1234 -> one cycle later flush = 1 and new_pc = 32'h0000_1234.
REQ-036 Bench SHALL check: exception with bus_busy_i = 1 for 3 cycles -> stall = 6'b111111 for 4 cycles, then a single flush cycle with new_pc = 32'h20.
REQ-037 Bench SHALL check: rst asserted while in WAIT_BUS -> no flush afterwards, stall = 0 and stall_cycles = 0.
REQ-038 Bench SHALL check: stallreq_mem held for 70000 cycles -> stall_cycles saturates and stays at 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hold/no-hold bit values, the stall
// vectors driven to the PC and the pipeline registers, and exception codes.
package pipe_ctrl_pkg;

    // Per-register hold flag values
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Stall vector layout: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM,
    // bit4 MEM/WB, bit5 WB. Each request freezes its stage and everything
    // upstream of it.
    localparam logic [5:0] STALL_NONE = {NoStop, NoStop, NoStop, NoStop, NoStop, NoStop};
    localparam logic [5:0] STALL_IF   = {NoStop, NoStop, NoStop, NoStop, Stop,   Stop};
    localparam logic [5:0] STALL_ID   = {NoStop, NoStop, NoStop, Stop,   Stop,   Stop};
    localparam logic [5:0] STALL_EX   = {NoStop, NoStop, Stop,   Stop,   Stop,   Stop};
    localparam logic [5:0] STALL_MEM  = {NoStop, Stop,   Stop,   Stop,   Stop,   Stop};
    localparam logic [5:0] STALL_ALL  = {Stop,   Stop,   Stop,   Stop,   Stop,   Stop};

    // Exception codes and entry point
    localparam logic [31:0] EXC_NONE   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;
    localparam logic [31:0] EXC_ERET   = 32'h0000_000e;

    // Stall-cycle counter ceiling
    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    // Priority encoder for stage hold requests: deepest stage wins
    function automatic logic [5:0] stall_select(
        input logic req_mem,
        input logic req_ex,
        input logic req_id,
        input logic req_if
    );
        logic [5:0] sel;
        sel = STALL_NONE;
        if (req_mem) begin
            sel = STALL_MEM;
        end else if (req_ex) begin
            sel = STALL_EX;
        end else if (req_id) begin
            sel = STALL_ID;
        end else if (req_if) begin
            sel = STALL_IF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline control: combines stage hold requests into the stall vector,
// turns MEM-stage exceptions into a one-cycle flush plus PC redirect (waiting
// for any in-flight bus transaction to finish), and counts stalled cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = pipe_ctrl_pkg::EXC_VECTOR,
    parameter logic [31:0] EXC_ERET   = pipe_ctrl_pkg::EXC_ERET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        bus_busy_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_BUS = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] target;
    logic        exc_take;
    logic [31:0] exc_target;

    // Exception acceptance and redirect target selection (RUN only)
    always_comb begin
        exc_take   = (state == RUN) && (excepttype_i != EXC_NONE);
        exc_target = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
    end

    // Stall vector: full freeze while an exception is pending, none while flushing
    always_comb begin
        stall = STALL_NONE;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (exc_take) begin
                        stall = STALL_ALL;
                    end else begin
                        stall = stall_select(stallreq_mem, stallreq_ex,
                                             stallreq_id, stallreq_if);
                    end
                end
                WAIT_BUS: stall = STALL_ALL;
                FLUSH:    stall = STALL_NONE;
                default:  stall = STALL_NONE;
            endcase
        end
    end

    // Redirect FSM; flush/new_pc are loaded on entry to FLUSH so they are
    // registered yet valid for exactly the FLUSH cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            flush  <= 1'b0;
            new_pc <= '0;
            target <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    flush  <= 1'b0;
                    new_pc <= '0;
                    if (exc_take) begin
                        target <= exc_target;
                        if (bus_busy_i) begin
                            state <= WAIT_BUS;
                        end else begin
                            state  <= FLUSH;
                            flush  <= 1'b1;
                            new_pc <= exc_target;
                        end
                    end
                end
                WAIT_BUS: begin
                    if (!bus_busy_i) begin
                        state  <= FLUSH;
                        flush  <= 1'b1;
                        new_pc <= target;
                    end
                end
                FLUSH: begin
                    state  <= RUN;
                    flush  <= 1'b0;
                    new_pc <= '0;
                end
                default: begin
                    state  <= RUN;
                    flush  <= 1'b0;
                    new_pc <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles with any stage held
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((stall != STALL_NONE) && (stall_cycles != STALL_CNT_MAX)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic        bus_busy_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [15:0] stall_cycles;

    int unsigned checks;
    int unsigned failures;
    int unsigned exp_sc;

    pipe_ctrl #(
        .EXC_VECTOR(32'h0000_0020),
        .EXC_ERET  (32'h0000_000e)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_if (stallreq_if),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .stallreq_mem(stallreq_mem),
        .excepttype_i(excepttype_i),
        .cp0_epc_i   (cp0_epc_i),
        .bus_busy_i  (bus_busy_i),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .stall_cycles(stall_cycles)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Settle, check stall, clock, then track and check the stall counter
    task automatic cyc(input string tag, input logic [5:0] exp_stall);
        #3;
        check({tag, "_stall"}, {26'd0, stall}, {26'd0, exp_stall});
        step();
        if (exp_stall != 6'd0 && exp_sc < 32'hFFFF) exp_sc++;
        check({tag, "_cnt"}, {16'd0, stall_cycles}, exp_sc);
    endtask

    task automatic set_req(input logic m, input logic e, input logic i, input logic f);
        stallreq_mem = m;
        stallreq_ex  = e;
        stallreq_id  = i;
        stallreq_if  = f;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        exp_sc       = 0;
        rst          = 1'b1;
        excepttype_i = 32'h0;
        cp0_epc_i    = 32'h0;
        bus_busy_i   = 1'b0;
        set_req(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset: stall forced low even with a request pending
        step();
        step();
        #3;
        check("rst_stall", {26'd0, stall}, 32'h0);
        check("rst_flush", {31'd0, flush}, 32'h0);
        check("rst_newpc", new_pc, 32'h0);
        check("rst_cnt", {16'd0, stall_cycles}, 32'h0);
        rst = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // Request priority
        set_req(1'b0, 1'b0, 1'b0, 1'b1); cyc("if_only", 6'b000011);
        set_req(1'b0, 1'b0, 1'b1, 1'b1); cyc("id_if", 6'b000111);
        set_req(1'b0, 1'b1, 1'b0, 1'b1); cyc("ex_if", 6'b001111);
        set_req(1'b1, 1'b1, 1'b1, 1'b1); cyc("all_req", 6'b011111);
        set_req(1'b0, 1'b0, 1'b0, 1'b0); cyc("no_req", 6'b000000);

        // General exception, bus idle, colliding with a stall request
        excepttype_i = 32'h8;
        set_req(1'b0, 1'b1, 1'b0, 1'b0);
        #3;
        check("exc_flush0", {31'd0, flush}, 32'h0);
        cyc("exc_stall", 6'b111111);
        // In FLUSH: requests and a new exception are ignored
        set_req(1'b1, 1'b1, 1'b1, 1'b1);
        #3;
        check("fl_flush", {31'd0, flush}, 32'h1);
        check("fl_newpc", new_pc, 32'h20);
        cyc("fl", 6'b000000);
        excepttype_i = 32'h0;
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        check("post_flush", {31'd0, flush}, 32'h0);
        check("post_newpc", new_pc, 32'h0);
        cyc("post", 6'b000000);

        // ERET returns to EPC
        excepttype_i = 32'he;
        cp0_epc_i    = 32'h0000_1234;
        cyc("eret", 6'b111111);
        excepttype_i = 32'h0;
        #3;
        check("eret_flush", {31'd0, flush}, 32'h1);
        check("eret_newpc", new_pc, 32'h0000_1234);
        cyc("eret_fl", 6'b000000);
        #3;
        check("eret_done", {31'd0, flush}, 32'h0);

        // Exception during a 3-cycle bus transaction; later codes ignored
        excepttype_i = 32'h8;
        bus_busy_i   = 1'b1;
        cyc("busy0", 6'b111111);
        excepttype_i = 32'he;
        cp0_epc_i    = 32'h0000_5555;
        #3;
        check("busy1_flush", {31'd0, flush}, 32'h0);
        cyc("busy1", 6'b111111);
        cyc("busy2", 6'b111111);
        bus_busy_i = 1'b0;
        #3;
        check("busy3_flush", {31'd0, flush}, 32'h0);
        cyc("busy3", 6'b111111);
        excepttype_i = 32'h0;
        #3;
        check("busy_fl", {31'd0, flush}, 32'h1);
        check("busy_newpc", new_pc, 32'h20);
        cyc("busy_fl", 6'b000000);
        #3;
        check("busy_done", {31'd0, flush}, 32'h0);

        // Reset while waiting on the bus abandons the redirect
        excepttype_i = 32'h8;
        bus_busy_i   = 1'b1;
        cyc("wb_enter", 6'b111111);
        excepttype_i = 32'h0;
        bus_busy_i   = 1'b0;
        rst          = 1'b1;
        #3;
        check("wb_rst_stall", {26'd0, stall}, 32'h0);
        step();
        rst    = 1'b0;
        exp_sc = 0;
        #3;
        check("wb_rst_flush", {31'd0, flush}, 32'h0);
        check("wb_rst_cnt", {16'd0, stall_cycles}, 32'h0);
        cyc("wb_after1", 6'b000000);
        #3;
        check("wb_after_flush", {31'd0, flush}, 32'h0);
        cyc("wb_after2", 6'b000000);

        // Counter saturation with a long MEM hold
        set_req(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65534; i++) step();
        check("sat_pre", {16'd0, stall_cycles}, 32'hFFFE);
        for (int i = 65534; i < 70000; i++) step();
        check("sat", {16'd0, stall_cycles}, 32'hFFFF);
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check("sat_hold", {16'd0, stall_cycles}, 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
